// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential WIDTH x WIDTH multiplier among NREQ requesters; MULT_ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority (lowest index wins).
// Latency: grant/mult_start one cycle after req is sampled in IDLE; done pulses multiplier busy time + 2 cycles after grant.
// Backpressure: req is a level held until done; requests are only arbitrated in IDLE, so one operation is in flight at a time.
module mult_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  busy,
    output logic                  mult_start,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic [2*WIDTH-1:0]    mult_result,
    input  logic                  mult_ready
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     win_reg;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     rr_next;
    logic [IW:0]       cand;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        // Walk the search order backwards so the first requester at or after rr_ptr is the one left standing.
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
        rr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_a = a_in[i*WIDTH +: WIDTH];
                sel_b = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            done       <= '0;
            result     <= '0;
            busy       <= 1'b0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            win_reg    <= '0;
`ifdef MULT_ARB_ROUND_ROBIN_EN
            rr_ptr     <= '0;
`endif
        end else begin
            grant      <= '0;
            done       <= '0;
            mult_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant      <= ONE << win_idx;
                        mult_start <= 1'b1;
                        mult_a     <= sel_a;
                        mult_b     <= sel_b;
                        win_reg    <= win_idx;
                        busy       <= 1'b1;
                        state      <= WAIT_BUSY;
`ifdef MULT_ARB_ROUND_ROBIN_EN
                        rr_ptr     <= rr_next;
`endif
                    end
                end
                // Ready dropping is the multiplier's acknowledgement of the start pulse.
                WAIT_BUSY: begin
                    if (!mult_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mult_ready) begin
                        result <= mult_result;
                        done   <= ONE << win_reg;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural sequential multiplier plus a reference model of arbitration order, latency and products.
module tb_mult_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [2*W-1:0]    result;
    logic              busy;
    logic              mult_start;
    logic [W-1:0]      mult_a;
    logic [W-1:0]      mult_b;
    logic [2*W-1:0]    mult_result;
    logic              mult_ready;

    int n_asserts = 0;
    int n_fail    = 0;
    int mlat      = 3;
    int rr_m      = 0;
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    mult_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_result(mult_result), .mult_ready(mult_ready)
    );

    always #5 clk = ~clk;

    // Sequential multiplier: ready low for mlat cycles after an accepted start, junk on the result bus meanwhile.
    logic [W-1:0] m_a, m_b;
    int           m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            mult_ready  <= 1'b1;
            mult_result <= '0;
            m_cnt       <= 0;
        end else if (mult_ready && mult_start) begin
            mult_ready  <= 1'b0;
            mult_result <= 48'hA5A5_5A5A_A5A5;
            m_a         <= mult_a;
            m_b         <= mult_b;
            m_cnt       <= mlat;
        end else if (!mult_ready) begin
            if (m_cnt <= 1) begin
                mult_ready  <= 1'b1;
                mult_result <= (2*W)'(m_a) * (2*W)'(m_b);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        opa[i] = a;
        opb[i] = b;
    endtask

    // Reference arbitration: next pending requester in rotation from the pointer, or lowest index.
    function automatic int ref_pick(input logic [NREQ-1:0] p, input int ptr);
`ifdef MULT_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < NREQ; i++) if (p[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
`else
        for (int i = 0; i < NREQ; i++) if (p[i]) return i;
`endif
        return 0;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mult_start"}, mult_start, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_mult_a"}, mult_a, 0);
        chk({tag, "_mult_b"}, mult_b, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk_zero(tag);
        rst  = 1'b0;
        rr_m = 0;
    endtask

    // One full operation: expected winner, latencies, operands and product all come from the model.
    task automatic do_op(input bit scramble, input bit drop, input logic [NREQ-1:0] add);
        int w, cyc, stray;
        logic [W-1:0]   ea, eb;
        logic [2*W-1:0] prod;
        w    = ref_pick(req, rr_m);
        ea   = opa[w];
        eb   = opb[w];
        prod = (2*W)'(ea) * (2*W)'(eb);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (grant == '0 && cyc < 20);
        chk("grant_latency", cyc, 1);
        chk("grant_onehot", grant, NREQ'(1) << w);
        chk("mult_start", mult_start, 1);
        chk("busy_at_grant", busy, 1);
        chk("mult_a", mult_a, ea);
        chk("mult_b", mult_b, eb);
        rr_m = (w + 1) % NREQ;
        if (scramble) set_ops(w, W'($urandom()), W'($urandom()));
        cyc   = 0;
        stray = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (grant != '0 || mult_start || !busy) stray++;
        end while (done == '0 && cyc < 60);
        chk("done_latency", cyc, mlat + 2);
        chk("no_stray_pulses", stray, 0);
        chk("done_onehot", done, NREQ'(1) << w);
        chk("result", result, prod);
        if (drop) req[w] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (add[i] && !req[i]) begin
                set_ops(i, W'($urandom()), W'($urandom()));
                req[i] = 1'b1;
            end
        end
        @(negedge clk);
        chk("done_clears", done, 0);
        chk("busy_clears", busy, 0);
        chk("result_holds", result, prod);
    endtask

    initial begin
        int cyc, stray;
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        do_reset("reset");

        // Single request 11*3
        mlat = 3;
        set_ops(0, 24'd11, 24'd3);
        req[0] = 1'b1;
        do_op(0, 1, '0);
        chk("single_result", result, 33);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (grant != '0 || busy || mult_start) stray++;
        end
        chk("idle_after_single", stray, 0);

        // All four at once, each dropped at its own done
        do_reset("reset_all4");
        set_ops(0, 24'd2, 24'd3);
        set_ops(1, 24'd4, 24'd5);
        set_ops(2, 24'd6, 24'd7);
        set_ops(3, 24'd8, 24'd9);
        req = '1;
        for (int k = 0; k < 4; k++) begin
            mlat = 1 + k;
            do_op(0, 1, '0);
        end

        // Same, but requester 0 stays up after its first done
        do_reset("reset_rerais");
        set_ops(0, 24'd2, 24'd3);
        set_ops(1, 24'd4, 24'd5);
        set_ops(2, 24'd6, 24'd7);
        set_ops(3, 24'd8, 24'd9);
        req  = '1;
        mlat = 2;
        do_op(0, 0, '0);
        for (int k = 0; k < 4; k++) do_op(0, 1, '0);
        chk("rerais_all_served", req, 0);

        // Continuous requesters 0 and 2
        do_reset("reset_cont");
        set_ops(0, 24'd100, 24'd7);
        set_ops(2, 24'd300, 24'd9);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) do_op(0, 0, '0);

        // Maximum operands
        do_reset("reset_max");
        mlat = 4;
        set_ops(2, 24'hFFFFFF, 24'hFFFFFF);
        req[2] = 1'b1;
        do_op(0, 1, '0);
        chk("max_product", result, 48'hFFFFFE000001);

        // Operands change right after grant
        do_reset("reset_latch");
        set_ops(1, 24'd1234, 24'd567);
        req[1] = 1'b1;
        do_op(1, 1, '0);
        chk("latched_product", result, 699678);

        // Reset while waiting on the multiplier
        do_reset("reset_pre_abort");
        mlat = 8;
        set_ops(1, 24'd100, 24'd200);
        req[1] = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (grant == '0 && cyc < 20);
        chk("abort_grant", grant, 4'b0010);
        repeat (4) @(negedge clk);
        do_reset("abort");
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done != '0 || busy || grant != '0) stray++;
        end
        chk("abort_no_done", stray, 0);
        mlat = 2;
        set_ops(3, 24'd5000, 24'd3000);
        req[3] = 1'b1;
        do_op(0, 1, '0);

        // Randomized traffic
        do_reset("reset_rand");
        for (int k = 0; k < 40; k++) begin
            if (req == '0) begin
                int i;
                i = $urandom_range(0, NREQ - 1);
                if ($urandom_range(0, 7) == 0) set_ops(i, 24'hFFFFFF, W'($urandom()));
                else set_ops(i, W'($urandom()), W'($urandom()));
                req[i] = 1'b1;
            end
            mlat = $urandom_range(1, 6);
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NREQ'($urandom()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one sequential 24x24 multiplier (start/ready handshake, 48-bit result) among several requesters. Selects one pending request, latches its operands, starts the multiplier, waits for completion and returns the product to the winning requester with a one-cycle done pulse. Sits between client logic and the multiplier top; the multiplier and arbiter share the same clock and reset.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 24: operand width; product is 2*WIDTH
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; level, held until done
- a_in  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- b_in  in  NREQ*WIDTH  operand B, same packing
- grant  out  NREQ  one-hot, one-cycle pulse when requester's operands are latched
- done  out  NREQ  one-hot, one-cycle pulse when result is valid for that requester
- result  out  2*WIDTH  product of last completed operation; holds until next done
- busy  out  1  high from grant through done inclusive
- mult_start  out  1  one-cycle start pulse to multiplier
- mult_a, mult_b  out  WIDTH  operands to multiplier; stable from start until completion
- mult_result  in  2*WIDTH  multiplier product
- mult_ready  in  1  multiplier idle/result-valid flag

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: if any req bit high, choose winner (see Configuration), latch a/b slices into mult_a/mult_b, register winner index, assert grant[winner] and mult_start for one cycle, go WAIT_BUSY. No req: stay.
- WAIT_BUSY: wait for mult_ready==0 (multiplier accepted start), then WAIT_DONE.
- WAIT_DONE: on mult_ready==1, capture mult_result into result, go DONE.
- DONE: done[winner]=1 for one cycle, return to IDLE.
- Operands latched at grant; requester may change a_in/b_in after grant pulse. req must stay high until done; req still high in the cycle after done counts as a new request (back-to-back allowed).
- req changes during WAIT_BUSY/WAIT_DONE/DONE are ignored until IDLE; dropping req mid-operation does not abort — done still pulses.
- Only one grant per IDLE visit; grant and done are never multi-hot.
- Product is unsigned, full 2*WIDTH, no truncation.

## Timing
- Reset (rst high at edge): state IDLE; grant, done, mult_start, busy = 0; result, mult_a, mult_b = 0; round-robin pointer = 0. Reset mid-operation aborts with no done pulse.
- req seen high at edge k in IDLE -> grant and mult_start high cycle k+1 (registered outputs).
- Arbiter latency overhead: grant-to-done = multiplier busy time + 2 cycles (WAIT_DONE detection, DONE).
- Minimum IDLE dwell between operations: 1 cycle; next grant earliest 2 cycles after done.
- busy rises with grant, falls in cycle after done.

## Configuration
- MULT_ARB_ROUND_ROBIN_EN defined: round-robin; search starts at pointer, pointer <= winner+1 (mod NREQ) on each grant. Continuously requesting clients are served in rotation.
- Undefined: fixed priority, lowest index wins; pointer logic absent.

## Test plan
- Reset then req[0]=1, a=11, b=3 -> one grant[0] pulse, one mult_start pulse, done[0] after multiplier completes, result=33, busy low afterwards.
- req[0..3] all asserted same cycle with distinct operands (2*3, 4*5, 6*7, 8*9), each held until own done -> with ROUND_ROBIN_EN grants in order 0,1,2,3 with results 6,20,42,72; without it order 0,1,2,3 as well but req[0] re-raised after its done preempts 1..3.
- Continuous req[0] and req[2] with ROUND_ROBIN_EN -> grants alternate 0,2,0,2; without macro req[2] starved.
- Max operands 0xFFFFFF*0xFFFFFF -> result 0xFFFFFE000001.
- Requester changes a_in the cycle after grant -> result uses latched operands.
- rst pulsed while in WAIT_DONE -> all outputs zero next cycle, no done pulse; new request afterwards completes correctly.
